fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage of the SimpleRISC pipeline; sits directly upstream of IM.
//  Owns the PC and drives IM's ena/addra; IM returns douta one clock later.
//  Presents {inst, pc} to the IF/OF latch with a valid/ready handshake.
//  Handles pipeline back-pressure, branch redirect from EX and halt.
// PARAMETERS
//  N         7   IM address width in words; IM depth = 2**N
//  RESET_PC  0   first PC fetched after reset (byte address, bits[1:0]=0)
// PORTS
//  clk            in   1   pipeline clock; also drives IM clka
//  rst_n          in   1   asynchronous, active-low reset
//  redirect_i     in   1   EX branch taken/call/ret: flush and refetch
//  redirect_pc_i  in   32  branch target (byte address; bits[1:0] ignored)
//  halt_i         in   1   stop fetching (sticky until redirect_i or reset)
//  ready_i        in   1   IF/OF latch accepts inst_o/pc_o this cycle
//  im_ena_o       out  1   IM read enable; when low, IM holds douta
//  im_addra_o     out  N   IM word address = fetch PC[N+1:2]
//  im_douta_i     in   32  IM read data, valid 1 clk after im_ena_o
//  valid_o        out  1   inst_o/pc_o hold a valid instruction
//  inst_o         out  32  instruction word (= im_douta_i)
//  pc_o           out  32  byte PC of inst_o
//  fetch_count_o  out  32  number of accepted transfers (valid_o & ready_i)
// BEHAVIOUR
//  Registers: state_q, fetch_pc_q (next PC to read), pc_q (PC of douta), valid_q, count_q.
//  Reset (async, rst_n=0): state=BOOT, fetch_pc_q=RESET_PC, pc_q=0, valid_q=0, count_q=0.
//   Outputs at reset: valid_o=0, pc_o=0, fetch_count_o=0, im_ena_o=0, im_addra_o=RESET_PC[N+1:2].
//  FSM states: BOOT, RUN, HALT.
//   BOOT: im_ena_o=1, addr=fetch_pc_q; -> RUN; valid_q<=1 (1st instr valid 2nd cycle after reset release).
//   RUN : advance = ~valid_q | ready_i; im_ena_o = advance | redirect_i.
//         im_addra_o = redirect_i ? redirect_pc_i[N+1:2] : fetch_pc_q[N+1:2].
//         On edge with im_ena_o: pc_q <= issued PC ({.., 2'b00}); fetch_pc_q <= issued PC + 4; valid_q<=1.
//         Stall (valid_q & ~ready_i & ~redirect_i): im_ena_o=0; IM, pc_q and valid_q hold. No instruction lost or duplicated.
//         halt_i & ~redirect_i: -> HALT, valid_q<=0, im_ena_o=0; current output is dropped.
//   HALT: im_ena_o=0, valid_o=0; redirect_i -> RUN with fetch of redirect_pc_i (same rules as RUN).
//  Redirect: valid_o = valid_q & ~redirect_i (combinational); the instruction on the output
//   during a redirect cycle is never transferred or counted. Target is valid the next cycle (0 bubbles).
//   redirect_i wins over halt_i and over ready_i=0.
//  pc_o = pc_q; inst_o = im_douta_i (no extra register; IM ena gating provides hold).
//  Counter: count_q += 1 on every valid_o & ready_i; wraps 2**32-1 -> 0.
//  PC arithmetic: 32-bit, +4 wraps modulo 2**32; IM address uses bits [N+1:2] only, so
//   fetches wrap modulo IM depth while pc_o keeps the full 32-bit value.
//  Reset mid-operation: everything returns to reset values asynchronously; the in-flight IM
//   read is ignored (valid_q=0), the fetch after release is RESET_PC.
// STRUCTURE
//  Shared defs file simplerisc_defs.vh: INSTR_W=32, PC_W=32, RESET_PC default,
//   fetch state encodings (BOOT/RUN/HALT).
//  No sub-module; single flat module (PC register, FSM, handshake, counter).
// TESTING  (N=7, RESET_PC=0, IM preloaded mem[i]=32'h100+i)
//  1 Release rst_n, ready_i=1 -> valid_o rises 2nd clk; (pc,inst)=(0,100),(4,101),(8,102) back-to-back.
//  2 ready_i=0 for 3 clks while pc_o=8 -> pc_o=8, inst_o=102 held, im_ena_o=0; then pc 12 inst 103, count +1 per accept.
//  3 redirect_i=1, redirect_pc_i=0x43 with pc_o=12, ready_i=1 -> count not incremented; next clk pc_o=0x40, inst=0x110.
//  4 redirect_i during stall (ready_i=0) -> next clk pc_o=target, valid_o=1, stalled instr never accepted.
//  5 Jump to 0x1FC -> pc_o sequence 0x1FC (inst 0x17F), 0x200 with im_addra=0, inst 0x100.
//  6 halt_i -> valid_o=0 next clk, im_ena_o=0 stays; redirect to 0x20 -> pc 0x20 inst 0x108;
//    assert rst_n=0 mid-stall -> valid_o=0, fetch_count_o=0 immediately; restart from pc 0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared SimpleRISC fetch definitions: datapath widths, default boot PC and fetch FSM encoding.
package fetch_unit_pkg;

   localparam int INSTR_W = 32;
   localparam int PC_W    = 32;

   localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the synchronous IM read port and
// hands {inst, pc} downstream with valid/ready, honouring stall, redirect and halt.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int              N        = 7,
   parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               redirect_i,
   input  logic [PC_W-1:0]    redirect_pc_i,
   input  logic               halt_i,
   input  logic               ready_i,
   output logic               im_ena_o,
   output logic [N-1:0]       im_addra_o,
   input  logic [INSTR_W-1:0] im_douta_i,
   output logic               valid_o,
   output logic [INSTR_W-1:0] inst_o,
   output logic [PC_W-1:0]    pc_o,
   output logic [31:0]        fetch_count_o
);

   fetch_state_e    state_q, state_d;
   logic [PC_W-1:0] fetch_pc_q, pc_q, issue_pc;
   logic            valid_q, issue, drop, advance;
   logic [31:0]     count_q;

   assign advance = ~valid_q | ready_i;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d  = state_q;
      issue    = 1'b0;
      drop     = 1'b0;
      issue_pc = fetch_pc_q;
      unique case (state_q)
         ST_BOOT: begin
            issue   = 1'b1;
            state_d = ST_RUN;
         end
         ST_RUN: begin
            if (redirect_i) begin
               issue    = 1'b1;
               issue_pc = redirect_pc_i & ~32'h3;
            end else if (halt_i) begin
               drop    = 1'b1;
               state_d = ST_HALT;
            end else begin
               issue = advance;
            end
         end
         ST_HALT: begin
            if (redirect_i) begin
               issue    = 1'b1;
               issue_pc = redirect_pc_i & ~32'h3;
               state_d  = ST_RUN;
            end
         end
         default: state_d = ST_BOOT;
      endcase
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_BOOT;
         fetch_pc_q <= RESET_PC;
         pc_q       <= '0;
         valid_q    <= 1'b0;
         count_q    <= '0;
      end else begin
         state_q <= state_d;
         if (issue) begin
            pc_q       <= issue_pc;
            fetch_pc_q <= issue_pc + 32'd4;
            valid_q    <= 1'b1;
         end else if (drop) begin
            valid_q <= 1'b0;
         end
         if (valid_o && ready_i) count_q <= count_q + 32'd1;
      end
   end

   // The BOOT read must not fire while reset is still held, hence the rst_n gate.
   assign im_ena_o      = issue & rst_n;
   assign im_addra_o    = issue_pc[N+1:2];
   assign valid_o       = valid_q & ~redirect_i;
   assign inst_o        = im_douta_i;
   assign pc_o          = pc_q;
   assign fetch_count_o = count_q;

endmodule
